// File: rtl/picoctrl_sequencer.sv
// picoctrl_sequencer
//   Tiny ROM-driven control sequencer. Each instruction takes two cycles:
//   FETCH latches rom_data into the instruction register, and EXEC evaluates
//   the condition, performs the action, and updates the program counter.
//
//   Instruction word: [15:13] cond, [12:10] action, [9:8] reg select,
//                     [7:0] immediate.
//
// Ports
//   clk        in   single clock, rising edge
//   reset_n    in   asynchronous active-low reset
//   en         in   run enable, sampled only in FETCH
//   c_in[1:0]  in   asynchronous condition inputs (synchronized internally)
//   rom_addr   out  instruction address (equals pc)
//   rom_data   in   instruction word, combinationally valid from rom_addr
//   out_reg    out  four DATA_W-wide output registers, reg n at [n*DATA_W +: DATA_W]
//   wr_strobe  out  one-hot, one-cycle pulse following an output-register write
//   stack_err  out  sticky call-stack overflow/underflow flag
module picoctrl_sequencer #(
    parameter int unsigned ADDR_W      = 5,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned STACK_DEPTH = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                en,
    input  logic [1:0]          c_in,
    output logic [ADDR_W-1:0]   rom_addr,
    input  logic [15:0]         rom_data,
    output logic [4*DATA_W-1:0] out_reg,
    output logic [3:0]          wr_strobe,
    output logic                stack_err
);

    localparam int unsigned SP_W = $clog2(STACK_DEPTH + 1);

    typedef enum logic {
        FETCH,
        EXEC
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [15:0]         ir_q, ir_d;
    logic [4*DATA_W-1:0] out_reg_q, out_reg_d;
    logic [3:0]          wr_strobe_q, wr_strobe_d;
    logic [SP_W-1:0]     sp_q, sp_d;
    logic                stack_err_q, stack_err_d;
    logic [ADDR_W-1:0]   stack_q [STACK_DEPTH];
    logic [ADDR_W-1:0]   stack_d [STACK_DEPTH];
    logic [1:0]          c_meta_q;
    logic [1:0]          c_sync_q;

    logic [2:0]          cond;
    logic [2:0]          action;
    logic [1:0]          sel;
    logic [7:0]          imm;
    logic                cond_true;
    logic [ADDR_W-1:0]   pc_inc;
    logic [ADDR_W-1:0]   target;

    assign cond   = ir_q[15:13];
    assign action = ir_q[12:10];
    assign sel    = ir_q[9:8];
    assign imm    = ir_q[7:0];
    assign pc_inc = pc_q + ADDR_W'(1);
    assign target = ADDR_W'(imm);

    // Conditions only ever look at the synchronized copy of c_in.
    always_comb begin
        cond_true = 1'b0;
        case (cond)
            3'b000:  cond_true = 1'b1;
            3'b010:  cond_true = ~c_sync_q[0];
            3'b011:  cond_true = c_sync_q[0];
            3'b100:  cond_true = ~c_sync_q[1];
            3'b101:  cond_true = c_sync_q[1];
            3'b110:  cond_true = c_sync_q[0] & c_sync_q[1];
            default: cond_true = 1'b0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        out_reg_d   = out_reg_q;
        wr_strobe_d = '0;
        sp_d        = sp_q;
        stack_err_d = stack_err_q;
        stack_d     = stack_q;

        unique case (state_q)
            FETCH: begin
                if (en) begin
                    ir_d    = rom_data;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                state_d = FETCH;
                pc_d    = pc_inc;
                if (cond_true) begin
                    case (action)
                        3'b001: begin
                            for (int unsigned n = 0; n < 4; n++) begin
                                if (sel == 2'(n)) begin
                                    out_reg_d[n*DATA_W +: DATA_W] = DATA_W'(imm);
                                    wr_strobe_d[n]                = 1'b1;
                                end
                            end
                        end
                        3'b010: pc_d = target;
                        3'b011: begin
                            if (sp_q == SP_W'(STACK_DEPTH)) begin
                                stack_err_d = 1'b1;
                            end else begin
                                // Stack slots are addressed by comparison so the
                                // pointer may be wider than the slot index.
                                for (int unsigned i = 0; i < STACK_DEPTH; i++) begin
                                    if (sp_q == SP_W'(i)) begin
                                        stack_d[i] = pc_inc;
                                    end
                                end
                                sp_d = sp_q + SP_W'(1);
                                pc_d = target;
                            end
                        end
                        3'b100: begin
                            if (sp_q == '0) begin
                                stack_err_d = 1'b1;
                            end else begin
                                for (int unsigned i = 0; i < STACK_DEPTH; i++) begin
                                    if (sp_q == SP_W'(i + 1)) begin
                                        pc_d = stack_q[i];
                                    end
                                end
                                sp_d = sp_q - SP_W'(1);
                            end
                        end
                        default: ;
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= FETCH;
            pc_q        <= '0;
            ir_q        <= '0;
            out_reg_q   <= '0;
            wr_strobe_q <= '0;
            sp_q        <= '0;
            stack_err_q <= 1'b0;
            c_meta_q    <= '0;
            c_sync_q    <= '0;
            for (int unsigned i = 0; i < STACK_DEPTH; i++) begin
                stack_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            out_reg_q   <= out_reg_d;
            wr_strobe_q <= wr_strobe_d;
            sp_q        <= sp_d;
            stack_err_q <= stack_err_d;
            c_meta_q    <= c_in;
            c_sync_q    <= c_meta_q;
            stack_q     <= stack_d;
        end
    end

    assign rom_addr  = pc_q;
    assign out_reg   = out_reg_q;
    assign wr_strobe = wr_strobe_q;
    assign stack_err = stack_err_q;

endmodule

// File: tb/tb_picoctrl_sequencer.sv
// Self-checking bench for picoctrl_sequencer: an instruction-level reference
// model (arrays, a queue for the call stack) is compared against the DUT on
// every falling clock edge, plus directed scenarios with literal expectations.
module tb_picoctrl_sequencer;

    logic        clk     = 1'b0;
    logic        reset_n = 1'b1;
    logic        en      = 1'b0;
    logic [1:0]  c_in    = 2'b00;
    logic [4:0]  rom_addr;
    logic [15:0] rom_data;
    logic [31:0] out_reg;
    logic [3:0]  wr_strobe;
    logic        stack_err;

    logic [15:0] rom [32];
    int          n_checks = 0;
    int          n_errors = 0;

    always #5 clk = ~clk;

    assign rom_data = rom[rom_addr];

    picoctrl_sequencer #(
        .ADDR_W     (5),
        .DATA_W     (8),
        .STACK_DEPTH(4)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .en       (en),
        .c_in     (c_in),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .out_reg  (out_reg),
        .wr_strobe(wr_strobe),
        .stack_err(stack_err)
    );

    // ---------------- reference model ----------------
    int          m_pc;
    bit          m_busy;       // an instruction has been fetched and awaits execution
    logic [15:0] m_ir;
    logic [7:0]  m_regs [4];
    logic [3:0]  m_strobe;
    bit          m_err;
    int          m_stack [$];
    logic [1:0]  m_s1, m_s2;

    function automatic bit cond_holds(input logic [2:0] c, input logic [1:0] s);
        case (c)
            3'd0:    return 1'b1;
            3'd2:    return s[0] == 1'b0;
            3'd3:    return s[0] == 1'b1;
            3'd4:    return s[1] == 1'b0;
            3'd5:    return s[1] == 1'b1;
            3'd6:    return s[0] && s[1];
            default: return 1'b0;
        endcase
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_pc = 0; m_busy = 0; m_ir = 0; m_strobe = 0; m_err = 0;
            m_stack.delete();
            m_s1 = 0; m_s2 = 0;
            for (int i = 0; i < 4; i++) m_regs[i] = 0;
        end else begin
            m_strobe = 0;
            if (m_busy) begin
                int nxt;
                int tgt;
                nxt = (m_pc + 1) % 32;
                tgt = m_ir[7:0] % 32;
                if (cond_holds(m_ir[15:13], m_s2)) begin
                    case (m_ir[12:10])
                        3'd1: begin
                            m_regs[m_ir[9:8]] = m_ir[7:0];
                            m_strobe = 4'b0001 << m_ir[9:8];
                        end
                        3'd2: nxt = tgt;
                        3'd3: begin
                            if (m_stack.size() < 4) begin
                                m_stack.push_back(nxt);
                                nxt = tgt;
                            end else m_err = 1;
                        end
                        3'd4: begin
                            if (m_stack.size() > 0) nxt = m_stack.pop_back();
                            else m_err = 1;
                        end
                        default: ;
                    endcase
                end
                m_pc   = nxt;
                m_busy = 0;
            end else if (en) begin
                m_ir   = rom[m_pc];
                m_busy = 1;
            end
            m_s2 = m_s1;
            m_s1 = c_in;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (reset_n) begin
            check("model_pc", 32'(rom_addr), 32'(m_pc));
            check("model_out_reg", out_reg, {m_regs[3], m_regs[2], m_regs[1], m_regs[0]});
            check("model_strobe", 32'(wr_strobe), 32'(m_strobe));
            check("model_err", 32'(stack_err), 32'(m_err));
        end
    end

    // ---------------- stimulus ----------------
    task automatic rom_clear();
        for (int i = 0; i < 32; i++) rom[i] = 16'h0000;
    endtask

    task automatic do_reset(input logic [1:0] c);
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        en      = 1'b0;
        c_in    = c;
        @(negedge clk);
        #2;
        reset_n = 1'b1;
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    logic [15:0] w;
    bit          found;

    initial begin
        rom_clear();
        #1 reset_n = 1'b0;
        #1;
        check("reset_pc", 32'(rom_addr), 0);
        check("reset_out", out_reg, 0);
        check("reset_strobe", 32'(wr_strobe), 0);
        check("reset_err", 32'(stack_err), 0);

        // write with strobe
        rom_clear();
        rom[0] = 16'h05A5;                  // always, write reg1 <- A5
        do_reset(2'b00);
        en = 1'b1;
        step(2);
        check("A_reg1", 32'(out_reg[15:8]), 32'hA5);
        check("A_strobe", 32'(wr_strobe), 32'b0010);
        check("A_pc", 32'(rom_addr), 1);
        step(1);
        check("A_strobe_off", 32'(wr_strobe), 0);

        // busy-wait on c1
        rom_clear();
        rom[1] = 16'hA801;                  // if c1: jump 1
        do_reset(2'b10);
        en = 1'b1;
        step(4);
        check("B_hold1", 32'(rom_addr), 1);
        step(10);
        check("B_hold2", 32'(rom_addr), 1);
        c_in  = 2'b00;
        found = 1'b0;
        for (int k = 0; k < 8 && !found; k++) begin
            @(negedge clk);
            if (rom_addr == 5'd2) found = 1'b1;
        end
        check("B_exit", 32'(found), 1);

        // wrap from 31
        rom_clear();
        rom[0] = 16'h081F;                  // jump 31
        do_reset(2'b00);
        en = 1'b1;
        step(2);
        check("C_at31", 32'(rom_addr), 31);
        step(2);
        check("C_wrap", 32'(rom_addr), 0);
        check("C_nostrobe", 32'(wr_strobe), 0);

        // call / return, then an extra return proves the stack is empty again
        rom_clear();
        rom[3]  = 16'h0C10;                 // call 16
        rom[16] = 16'h1000;                 // return
        rom[4]  = 16'h1000;                 // return on empty stack
        do_reset(2'b00);
        en = 1'b1;
        step(8);
        check("D_call", 32'(rom_addr), 16);
        step(2);
        check("D_ret", 32'(rom_addr), 4);
        check("D_noerr", 32'(stack_err), 0);
        step(2);
        check("D_empty_pc", 32'(rom_addr), 5);
        check("D_empty_err", 32'(stack_err), 1);

        // overflow on the fifth nested call
        rom_clear();
        for (int i = 0; i < 5; i++) rom[i] = 16'h0C00 | 16'(i + 1);
        do_reset(2'b00);
        en = 1'b1;
        step(8);
        check("E_fourth", 32'(rom_addr), 4);
        check("E_fourth_err", 32'(stack_err), 0);
        step(2);
        check("E_ovf_pc", 32'(rom_addr), 5);
        check("E_ovf_err", 32'(stack_err), 1);
        step(6);
        check("E_sticky", 32'(stack_err), 1);

        // underflow straight after reset
        rom_clear();
        rom[0] = 16'h1000;
        do_reset(2'b00);
        en = 1'b1;
        step(2);
        check("E_unf_pc", 32'(rom_addr), 1);
        check("E_unf_err", 32'(stack_err), 1);

        // asynchronous reset during EXEC of a write
        rom_clear();
        rom[0] = 16'h0711;                  // reg3 <- 11
        rom[1] = 16'h063C;                  // reg2 <- 3C
        do_reset(2'b00);
        en = 1'b1;
        step(2);
        check("F_pre_out", out_reg, 32'h1100_0000);
        step(1);
        #2 reset_n = 1'b0;
        #1;
        check("F_async_pc", 32'(rom_addr), 0);
        check("F_async_out", out_reg, 0);
        check("F_async_strobe", 32'(wr_strobe), 0);
        @(negedge clk);
        check("F_held_strobe", 32'(wr_strobe), 0);
        #2 reset_n = 1'b1;
        step(2);
        check("F_restart_out", out_reg, 32'h1100_0000);
        check("F_restart_pc", 32'(rom_addr), 1);

        // randomized programs, enables, conditions and reset pulses
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 32; i++) begin
                w = 16'($urandom);
                if ($urandom_range(0, 2) == 0) w[15:13] = 3'b000;
                rom[i] = w;
            end
            do_reset(2'($urandom));
            repeat (400) begin
                @(negedge clk);
                en = ($urandom_range(0, 9) != 0);
                if ($urandom_range(0, 3) == 0) c_in = 2'($urandom);
                if ($urandom_range(0, 149) == 0) begin
                    #2 reset_n = 1'b0;
                    #2 reset_n = 1'b1;
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/picoctrl_sequencer.md
PICOCTRL_SEQUENCER -- requirements
Module: picoctrl_sequencer

Interface
REQ-001 SHALL have parameter ADDR_W, default 5, program-counter and ROM-address width (32 words).
REQ-002 SHALL have parameter DATA_W, default 8, output-register and immediate width.
REQ-003 SHALL have parameter STACK_DEPTH, default 4, number of call-return stack entries.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-005 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port en  input  1  run enable; when 0, the sequencer holds in FETCH.
REQ-007 SHALL have port c_in  input  2  asynchronous condition inputs c0 (bit 0) and c1 (bit 1).
REQ-008 SHALL have port rom_addr  output  ADDR_W  instruction address, equal to pc.
REQ-009 SHALL have port rom_data  input  16  instruction word, combinationally valid from rom_addr in the same cycle.
REQ-010 SHALL have port out_reg  output  4*DATA_W  four output registers; reg n occupies bits [8n+7:8n].
REQ-011 SHALL have port wr_strobe  output  4  one-hot pulse, one cycle wide, marking an output-register update.
REQ-012 SHALL have port stack_err  output  1  sticky flag for call-stack overflow or underflow.

Function
REQ-013 SHALL decode instruction fields as follows: [15:13] cond, [12:10] action, [9:8] reg select, [7:0] immediate.
REQ-014 SHALL evaluate cond as: 000 always; 001 never; 010 c0==0; 011 c0==1; 100 c1==0; 101 c1==1; 110 c0&c1; 111 never.
REQ-015 SHALL decode action as: 000 nop; 001 write imm to reg; 010 jump to imm[4:0]; 011 call imm[4:0]; 100 return; 101-111 nop.
REQ-016 SHALL pass c_in through a 2-flop synchronizer per bit and SHALL use only the synchronized values in condition evaluation.
REQ-017 SHALL implement a two-state FSM with states FETCH and EXEC.
REQ-018 In FETCH with en=1, SHALL latch rom_data into the instruction register and move to EXEC; with en=0, SHALL stay in FETCH and change no state.
REQ-019 In EXEC, SHALL evaluate the condition, perform the action only if the condition is true, update pc, and return to FETCH; each instruction therefore takes exactly 2 cycles.
REQ-020 SHALL set next pc to pc+1 modulo 32 (31 wraps to 0) for false conditions, nop, write, and faulted call/return.
REQ-021 For a true write, SHALL update out_reg[reg] in EXEC and SHALL assert wr_strobe[reg]=1 in the following cycle only.
REQ-022 For a true jump, SHALL set pc to imm[4:0]; a jump to its own address busy-waits and re-evaluates the condition every 2 cycles.
REQ-023 For a true call with stack not full, SHALL push pc+1 (mod 32), set pc to imm[4:0], and increment the stack pointer.
REQ-024 For a true call with stack full, SHALL not push or jump, SHALL set stack_err=1, and SHALL advance pc by 1.
REQ-025 For a true return with stack not empty, SHALL pop the top entry into pc.
REQ-026 For a true return with stack empty, SHALL set stack_err=1 and advance pc by 1.
REQ-027 Once set, stack_err SHALL remain 1 until reset.
REQ-028 Dropping en mid-instruction SHALL not abort it: EXEC always completes, and en is sampled only in FETCH.

Reset
REQ-029 On reset_n=0, SHALL immediately clear: pc=0, state=FETCH, instruction register=0, out_reg=0, wr_strobe=0, stack pointer=0, stack_err=0, synchronizers=0.
REQ-030 Reset asserted mid-instruction or mid-busy-wait SHALL discard that instruction; execution restarts at address 0 on the first en=1 FETCH after release.

Verification
REQ-031 Write/strobe: ROM[0]={000,001,01,8'hA5}, en=1 -> out_reg[15:8]=8'hA5 after EXEC; wr_strobe=4'b0010 for exactly one cycle; pc=1.
REQ-032 Busy-wait: ROM[1]={101,010,00,8'h01} with c1=1 -> pc stays 1; drop c1 to 0 -> pc=2 within 2 synchronizer cycles plus 2 instruction cycles.
REQ-033 Wrap: a nop stream from address 31 -> next rom_addr=0; no strobe asserted.
REQ-034 Call/return: call 8'h10 at addr 3, then return at addr 16 -> pc=16, then pc=4; stack pointer returns to 0; stack_err=0.
REQ-035 Stack faults: 5 nested calls -> fifth call leaves pc at its address+1 and sets stack_err=1; separately, a return with empty stack -> stack_err=1 and pc+1.
REQ-036 Async reset: assert reset_n=0 during EXEC of a write -> no strobe, out_reg=0, pc=0 immediately, without waiting for a clock edge.
